// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, LSB first, start/busy/done handshake
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;

    assign w_accept   = start && (r_state != S_RUN);
    assign w_last     = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));

    // Full-subtractor cell on the current operand LSBs and stored borrow
    assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = start ? S_RUN : S_IDLE;
            S_RUN:   w_next_state = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_res   <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (r_state == S_RUN) begin
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_res <= w_res_next;
            r_br  <= w_br_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Result registers only move on completion, so they stay stable across a following RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_br_next;
            r_ovf  <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
            r_zero <= (w_res_next == '0);
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor with directed vectors
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        logic         z;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc   = 0;
    logic [W-1:0] last_diff;
    int           busy_run;
    logic         prev_done;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse and checks hold/pulse/busy-length rules
    always @(negedge clk) begin
        if (!rst_n) begin
            last_diff = '0;
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) begin
                busy_run++;
                check("diff_hold_during_run", 32'(diff), 32'(last_diff));
            end else if (busy_run != 0) begin
                check("busy_length", 32'(busy_run), 32'(W));
                busy_run = 0;
            end
            if (done) begin
                exp_t e;
                check("done_single_cycle", 32'(prev_done), 32'd0);
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("diff", 32'(diff), 32'(e.d));
                    check("bout", 32'(bout), 32'(e.bo));
                    check("ovf",  32'(ovf),  32'(e.ov));
                    check("zero", 32'(zero), 32'(e.z));
                    check("done_latency_cycle", 32'(cyc), 32'(e.cyc));
                    last_diff = e.d;
                end
            end
            prev_done = done;
        end
    end

    task automatic push_exp(input logic [W-1:0] d, input logic bo, input logic ov, input logic z);
        exp_t e;
        e.d = d; e.bo = bo; e.ov = ov; e.z = z;
        e.cyc = cyc + 1 + W;
        q.push_back(e);
    endtask

    // Called at a negedge: present operands and start for one cycle, then scramble operands
    task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb);
        a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'hA5; b = 8'h3C;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_done_timeout", 32'(q.size()), 32'd0);
        @(negedge clk);
        check("done_dropped", 32'(done), 32'd0);
    endtask

    task automatic op(input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic [W-1:0] d, input logic bo, input logic ov, input logic z);
        push_exp(d, bo, ov, z);
        issue(va, vb);
        wait_idle();
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b0);
        op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0);
        op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);

        // Back-to-back: start held high in the done cycle
        push_exp(8'h00, 1'b0, 1'b0, 1'b1);
        issue(8'h33, 8'h33);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_done_seen", 32'(done), 32'd1);
        push_exp(8'hFF, 1'b1, 1'b0, 1'b0);
        issue(8'h00, 8'h01);
        check("b2b_busy_after_done", 32'(busy), 32'd1);
        check("b2b_done_fell", 32'(done), 32'd0);
        wait_idle();

        // start during RUN is ignored
        push_exp(8'h0E, 1'b0, 1'b0, 1'b0);
        issue(8'h0F, 8'h01);
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (12) @(negedge clk);

        // Asynchronous reset mid-RUN aborts with no done
        issue(8'h44, 8'h11);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        check("abort_ovf",  32'(ovf),  32'd0);
        check("abort_zero", 32'(zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        op(8'h44, 8'h11, 8'h33, 1'b0, 1'b0, 1'b0);

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
